// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch types and constants: NOP encoding, default reset vector, queue entry.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch bundle: instruction-memory request/response plus the decode-side IR port.
interface instr_fetch_queue_if;

  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDEN;
  logic [31:0] IMEM_DOUT;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_VALID;

  modport slave (
    output IMEM_ADDR, IMEM_RDEN, IR, IR_PC, IR_VALID,
    input  IMEM_DOUT, STALL, FLUSH, FLUSH_PC
  );

  modport master (
    input  IMEM_ADDR, IMEM_RDEN, IR, IR_PC, IR_VALID,
    output IMEM_DOUT, STALL, FLUSH, FLUSH_PC
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry queue of {instr, pc}; head is registered, clear beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_push,
  input  fetch_entry_t  i_push_dat,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !i_clear;
  assign w_pop   = i_pop && !i_clear && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential fetch with a small response queue, decode stall and flush redirect.
// FETCH_BYPASS_EN: forward a response straight to IR when the queue is empty.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter int          DEPTH     = 2
) (
  input  logic                CLK,
  input  logic                RST,
  instr_fetch_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_issue_addr;
  logic          r_inflight;
  logic          r_kill;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_resp_entry;
  logic          w_has;
  logic          w_resp;
  logic          w_byp;
  logic          w_pop;
  logic          w_push;
  logic [CW:0]   w_occ;
  logic          w_issue;

  assign w_has  = (w_count != '0);
  assign w_resp = r_inflight && !r_kill;

`ifdef FETCH_BYPASS_EN
  assign w_byp = !w_has && w_resp;
`else
  assign w_byp = 1'b0;
`endif

  assign bus.IR_VALID = w_has || w_byp;

  always_comb begin
    bus.IR    = NOP_INSTR;
    bus.IR_PC = 32'h0000_0000;
    if (w_has) begin
      bus.IR    = w_head.instr;
      bus.IR_PC = w_head.pc;
    end else if (w_byp) begin
      bus.IR    = bus.IMEM_DOUT;
      bus.IR_PC = r_issue_addr;
    end
  end

  assign w_pop  = bus.IR_VALID && !bus.STALL && !bus.FLUSH;
  // A bypassed word that decode takes this cycle never enters the queue.
  assign w_push = w_resp && !(w_byp && w_pop);

  assign w_resp_entry = '{instr: bus.IMEM_DOUT, pc: r_issue_addr};

  // Issue only if every word already owed to the queue still has a slot.
  assign w_occ   = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = !RST && !bus.FLUSH && (w_occ < (CW+1)'(DEPTH));

  assign bus.IMEM_RDEN = w_issue;
  assign bus.IMEM_ADDR = r_pc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc         <= RESET_VEC;
      r_issue_addr <= RESET_VEC;
      r_inflight   <= 1'b0;
      r_kill       <= 1'b0;
    end else if (bus.FLUSH) begin
      r_pc       <= word_align(bus.FLUSH_PC);
      r_kill     <= r_inflight;
      r_inflight <= 1'b0;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issue_addr <= r_pc;
        r_pc         <= r_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .i_push     (w_push),
    .i_push_dat (w_resp_entry),
    .i_pop      (w_pop && w_has),
    .i_clear    (bus.FLUSH),
    .o_count    (w_count),
    .o_head     (w_head)
  );

endmodule
